dmem_axi_bridge: RTL
====================

Name: dmem_axi_bridge

Overview:
- Data-memory port of the single-cycle MIPS core.
- Sits directly downstream of the core's memwrite/aluout/writedata outputs and returns readdata.
- Converts each core load/store into one single-beat AXI4-Lite transaction.
- Holds the core via cpu_stall until the transaction completes.

Parameters:
ADDR_W, 32, address width of cpu_addr and AXI araddr/awaddr
DATA_W, 32, data width; must be 32 (wstrb fixed 4 bits)
TIMEOUT, 255, watchdog limit in cycles; used only when DMEM_TIMEOUT_EN defined

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  load/store request (core memread | memwrite)
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  byte address (core aluout)
cpu_wdata  in  DATA_W  store data (core writedata)
cpu_rdata  out  DATA_W  load data (core readdata)
cpu_stall  out  1  freeze core PC/regfile while high
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  response error, valid with cpu_done
m_awaddr  out  ADDR_W  AXI write address
m_awvalid / m_awready  out / in  1  AW handshake
m_wdata  out  DATA_W  AXI write data
m_wstrb  out  4  always 4'hF
m_wvalid / m_wready  out / in  1  W handshake
m_bresp  in  2  write response
m_bvalid / m_bready  in / out  1  B handshake
m_araddr  out  ADDR_W  AXI read address
m_arvalid / m_arready  out / in  1  AR handshake
m_rdata  in  DATA_W  read data
m_rresp  in  2  read response
m_rvalid / m_rready  in / out  1  R handshake

Behaviour:
- States: IDLE, WREQ, WRESP, RREQ, RRESP, DONE.
- Reset (reset low, async): state IDLE; all m_*valid, m_bready, m_rready = 0; cpu_rdata = 0; cpu_done = 0; cpu_err = 0; address/data registers = 0.
- Reset mid-transaction: all valids drop immediately. The whole system resets together; no AXI completion is attempted.
- IDLE, cpu_req = 1:
  - Latch {cpu_addr[ADDR_W-1:2], 2'b00} and cpu_wdata. cpu_addr[1:0] is ignored.
  - Go to WREQ if cpu_we = 1, else RREQ.
- WREQ:
  - Assert m_awvalid and m_wvalid together.
  - Each valid deasserts on the cycle after its own ready is sampled high. AW and W handshakes are tracked independently and may complete in either order or in the same cycle.
  - When both have completed, go to WRESP.
- WRESP: m_bready = 1. On m_bvalid, capture err = m_bresp[1] and go to DONE.
- RREQ: m_arvalid = 1 until m_arready is sampled high, then go to RRESP.
- RRESP: m_rready = 1. On m_rvalid, load cpu_rdata <= m_rdata (also on error), capture err = m_rresp[1], go to DONE.
- DONE:
  - cpu_done = 1 and cpu_err = captured err, for exactly one cycle.
  - cpu_stall = 0. Next state is IDLE; cpu_req is not sampled in DONE.
- cpu_stall (combinational) = (state == IDLE & cpu_req) | state ∈ {WREQ, WRESP, RREQ, RRESP}.
- cpu_rdata holds its value until the next read completes. Stores do not change it.
- Latency with a zero-wait slave (ready/valid high immediately):
  - Write: request seen in cycle 0; AW/W handshakes in cycle 1; B in cycle 2; cpu_done in cycle 3.
  - Read: AR in cycle 1; R in cycle 2; cpu_done in cycle 3.
- m_wdata, m_awaddr and m_araddr are stable from valid assertion through handshake.
- At most one outstanding transaction; AXI IDs are not used.

Optional Feature:
- Macro DMEM_TIMEOUT_EN defined:
  - A counter clears on leaving IDLE and increments each cycle in WREQ/WRESP/RREQ/RRESP.
  - When it reaches TIMEOUT, all valids/readies drop and the state goes to DONE with cpu_err = 1.
  - cpu_rdata is unchanged on timeout.
- Macro not defined: no counter logic; the bridge waits indefinitely for the slave.

Test Plan:
- Store 0xA5A5_0001 to 0x0000_0104, zero-wait slave, bresp = 00 -> awaddr = 0x104, wdata = 0xA5A5_0001, wstrb = F; cpu_done in cycle 3 with cpu_err = 0; stall high in cycles 0–2.
- Store with wready high 3 cycles before awready -> wvalid drops after the W handshake, awvalid stays until awready; exactly one B accepted; cpu_done 2 cycles after the AW handshake.
- Load from 0x0000_0203, arready delayed 2 cycles, rvalid delayed 4 -> araddr = 0x200; cpu_rdata = 0x1234_5678 on cpu_done; cpu_rdata holds through a following store.
- Load with rresp = 10 (SLVERR), rdata 0xFFFF_0000 -> cpu_done with cpu_err = 1, cpu_rdata = 0xFFFF_0000.
- Reset asserted while in RRESP -> arvalid/rready = 0 and cpu_stall = 0 immediately; after release, a new load completes normally.
- With DMEM_TIMEOUT_EN and TIMEOUT = 8, a slave that never asserts arready -> cpu_done with cpu_err = 1 exactly 8 cycles after entering RREQ; arvalid = 0 afterwards.

Source files
------------

// File: rtl/dmem_axi_bridge.sv
// Data-memory port of the single-cycle MIPS core: each load/store becomes one AXI4-Lite beat.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN (limit set by TIMEOUT).
module dmem_axi_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREQ,
        ST_WRESP,
        ST_RREQ,
        ST_RRESP,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_c;
    logic              aw_fire_c, w_fire_c;
    logic              ign_unused;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Word alignment drops the byte offset; only the error bit of each response matters.
    assign ign_unused = ^{cpu_addr[1:0], m_bresp[0], m_rresp[0]};

    assign busy_c    = (state_q == ST_WREQ) || (state_q == ST_WRESP) ||
                       (state_q == ST_RREQ) || (state_q == ST_RRESP);
    assign aw_fire_c = awvalid_q && m_awready;
    assign w_fire_c  = wvalid_q && m_wready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = 1'b0;
        err_d     = err_q;
`ifdef DMEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d    = {cpu_addr[ADDR_W-1:2], 2'b00};
                    wdata_d   = cpu_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cpu_we) begin
                        state_d   = ST_WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RREQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            // AW and W complete independently, in any order.
            ST_WREQ: begin
                if (aw_fire_c) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire_c) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire_c) && (w_done_q || w_fire_c)) begin
                    state_d  = ST_WRESP;
                    bready_d = 1'b1;
                end
            end
            ST_WRESP: begin
                if (m_bvalid && bready_q) begin
                    bready_d = 1'b0;
                    err_d    = m_bresp[1];
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_RREQ: begin
                if (arvalid_q && m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RRESP;
                end
            end
            ST_RRESP: begin
                if (m_rvalid && rready_q) begin
                    rready_d = 1'b0;
                    rdata_d  = m_rdata;
                    err_d    = m_rresp[1];
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef DMEM_TIMEOUT_EN
        // Watchdog: abandon the transaction once the slave has stalled TIMEOUT cycles.
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (busy_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if ((state_d != ST_DONE) && (cnt_d == CNT_W'(TIMEOUT))) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                err_d     = 1'b1;
                done_d    = 1'b1;
                state_d   = ST_DONE;
            end
        end
`endif
    end

    assign cpu_stall = ((state_q == ST_IDLE) && cpu_req) || busy_c;
    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = 4'hF;
    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule
